// File: rtl/bypass_select_generator_pkg.sv
// ============================================================================
// Module  : bypass_select_generator_pkg
// Brief   : Shared types, stage constants and priority helper for bypass select.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bypass_select_generator_pkg;

    localparam int BYPASS_INT_EX_DEPTH = 1;
    localparam int BYPASS_MEM_MA_DEPTH = 2;

    localparam int LANE_IDX_W    = 2;
    localparam int MAX_INT_LANES = 1 << LANE_IDX_W;
    localparam int MAX_MEM_LANES = 1 << LANE_IDX_W;
    localparam int PREG_W_MAX    = 8;

    typedef enum logic [1:0] {
        STG_INT_EX = 2'd0,
        STG_INT_WB = 2'd1,
        STG_MEM_MA = 2'd2,
        STG_MEM_WB = 2'd3
    } bypass_stage_e;

    typedef struct packed {
        logic                  valid;
        bypass_stage_e         stg;
        logic [LANE_IDX_W-1:0] int_lane;
        logic [LANE_IDX_W-1:0] mem_lane;
    } bypass_select_t;

    typedef struct packed {
        bypass_select_t r_a;
        bypass_select_t r_b;
    } bypass_ctrl_t;

    typedef struct packed {
        logic                  valid;
        logic [PREG_W_MAX-1:0] preg;
    } bypass_track_entry_t;

    function automatic logic [LANE_IDX_W-1:0] lowest_idx(input logic [MAX_INT_LANES-1:0] v);
        logic [LANE_IDX_W-1:0] r;
        r = '0;
        for (int i = MAX_INT_LANES - 1; i >= 0; i--) begin
            if (v[i]) r = LANE_IDX_W'(i);
        end
        return r;
    endfunction

    // Youngest producer wins: INT_EX, MEM_MA, INT_WB, MEM_WB.
    function automatic bypass_select_t bypass_prioritize(
        input logic [MAX_INT_LANES-1:0] int_ex_hit,
        input logic [MAX_MEM_LANES-1:0] mem_ma_hit,
        input logic [MAX_INT_LANES-1:0] int_wb_hit,
        input logic [MAX_MEM_LANES-1:0] mem_wb_hit
    );
        bypass_select_t r;
        r = '0;
        if (|int_ex_hit) begin
            r.valid    = 1'b1;
            r.stg      = STG_INT_EX;
            r.int_lane = lowest_idx(int_ex_hit);
        end else if (|mem_ma_hit) begin
            r.valid    = 1'b1;
            r.stg      = STG_MEM_MA;
            r.mem_lane = lowest_idx(mem_ma_hit);
        end else if (|int_wb_hit) begin
            r.valid    = 1'b1;
            r.stg      = STG_INT_WB;
            r.int_lane = lowest_idx(int_wb_hit);
        end else if (|mem_wb_hit) begin
            r.valid    = 1'b1;
            r.stg      = STG_MEM_WB;
            r.mem_lane = lowest_idx(mem_wb_hit);
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bypass_select_generator_matcher.sv
// ============================================================================
// Module  : bypass_operand_matcher
// Brief   : Combinational compare of one source tag against all bypass candidates.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bypass_operand_matcher
    import bypass_select_generator_pkg::*;
#(
    parameter int INT_LANES = 2,
    parameter int MEM_LANES = 2
) (
    input  logic                                 src_valid,
    input  logic [PREG_W_MAX-1:0]                src,
    input  bypass_track_entry_t [INT_LANES-1:0]  int_ex_cand,
    input  bypass_track_entry_t [INT_LANES-1:0]  int_wb_cand,
    input  bypass_track_entry_t [MEM_LANES-1:0]  mem_ma_cand,
    input  bypass_track_entry_t [MEM_LANES-1:0]  mem_wb_cand,
    output bypass_select_t                       sel
);

    logic [MAX_INT_LANES-1:0] int_ex_hit;
    logic [MAX_INT_LANES-1:0] int_wb_hit;
    logic [MAX_MEM_LANES-1:0] mem_ma_hit;
    logic [MAX_MEM_LANES-1:0] mem_wb_hit;

    always_comb begin
        int_ex_hit = '0;
        int_wb_hit = '0;
        mem_ma_hit = '0;
        mem_wb_hit = '0;
        for (int l = 0; l < INT_LANES; l++) begin
            int_ex_hit[l] = src_valid && int_ex_cand[l].valid && (int_ex_cand[l].preg == src);
            int_wb_hit[l] = src_valid && int_wb_cand[l].valid && (int_wb_cand[l].preg == src);
        end
        for (int l = 0; l < MEM_LANES; l++) begin
            mem_ma_hit[l] = src_valid && mem_ma_cand[l].valid && (mem_ma_cand[l].preg == src);
            mem_wb_hit[l] = src_valid && mem_wb_cand[l].valid && (mem_wb_cand[l].preg == src);
        end
        sel = bypass_prioritize(int_ex_hit, mem_ma_hit, int_wb_hit, mem_wb_hit);
    end

endmodule

`default_nettype wire

// File: rtl/bypass_select_generator.sv
// ============================================================================
// Module  : bypass_select_generator
// Brief   : Tracks in-flight producer tags and registers per-consumer bypass selects.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bypass_select_generator
    import bypass_select_generator_pkg::*;
#(
    parameter int INT_LANES = 2,
    parameter int MEM_LANES = 2,
    parameter int CONSUMERS = 4,
    parameter int PREG_W    = 7
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 stall,
    input  logic                                 flush,
    input  logic [INT_LANES-1:0]                 int_issue_valid,
    input  logic [INT_LANES-1:0]                 int_writes_reg,
    input  logic [INT_LANES-1:0][PREG_W-1:0]     int_dst,
    input  logic [MEM_LANES-1:0]                 mem_issue_valid,
    input  logic [MEM_LANES-1:0]                 mem_writes_reg,
    input  logic [MEM_LANES-1:0][PREG_W-1:0]     mem_dst,
    input  logic [CONSUMERS-1:0]                 src_valid_a,
    input  logic [CONSUMERS-1:0]                 src_valid_b,
    input  logic [CONSUMERS-1:0][PREG_W-1:0]     src_a,
    input  logic [CONSUMERS-1:0][PREG_W-1:0]     src_b,
    output bypass_ctrl_t [CONSUMERS-1:0]         bypass_ctrl
);

    if (INT_LANES > MAX_INT_LANES || MEM_LANES > MAX_MEM_LANES || PREG_W > PREG_W_MAX) begin : g_param_check
        $error("bypass_select_generator: lane count or tag width exceeds package range");
    end

    bypass_track_entry_t [INT_LANES-1:0] int_issue;
    bypass_track_entry_t [MEM_LANES-1:0] mem_issue;
    bypass_track_entry_t [INT_LANES-1:0] int_ex_q;
    bypass_track_entry_t [MEM_LANES-1:0] mem_addr_q;
    bypass_track_entry_t [MEM_LANES-1:0] mem_ma_q;
    bypass_select_t      [CONSUMERS-1:0] match_a;
    bypass_select_t      [CONSUMERS-1:0] match_b;

    for (genvar l = 0; l < INT_LANES; l++) begin : g_int_issue
        assign int_issue[l].valid = int_issue_valid[l] && int_writes_reg[l];
        assign int_issue[l].preg  = PREG_W_MAX'(int_dst[l]);
    end

    for (genvar l = 0; l < MEM_LANES; l++) begin : g_mem_issue
        assign mem_issue[l].valid = mem_issue_valid[l] && mem_writes_reg[l];
        assign mem_issue[l].preg  = PREG_W_MAX'(mem_dst[l]);
    end

    // Candidates are the positions producers will occupy next cycle, when the mux uses the select.
    for (genvar c = 0; c < CONSUMERS; c++) begin : g_consumer
        bypass_operand_matcher #(.INT_LANES(INT_LANES), .MEM_LANES(MEM_LANES)) u_match_a (
            .src_valid   (src_valid_a[c]),
            .src         (PREG_W_MAX'(src_a[c])),
            .int_ex_cand (int_issue),
            .int_wb_cand (int_ex_q),
            .mem_ma_cand (mem_addr_q),
            .mem_wb_cand (mem_ma_q),
            .sel         (match_a[c])
        );
        bypass_operand_matcher #(.INT_LANES(INT_LANES), .MEM_LANES(MEM_LANES)) u_match_b (
            .src_valid   (src_valid_b[c]),
            .src         (PREG_W_MAX'(src_b[c])),
            .int_ex_cand (int_issue),
            .int_wb_cand (int_ex_q),
            .mem_ma_cand (mem_addr_q),
            .mem_wb_cand (mem_ma_q),
            .sel         (match_b[c])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ex_q    <= '0;
            mem_addr_q  <= '0;
            mem_ma_q    <= '0;
            bypass_ctrl <= '0;
        end else if (flush) begin
            int_ex_q    <= '0;
            mem_addr_q  <= '0;
            mem_ma_q    <= '0;
            bypass_ctrl <= '0;
        end else if (!stall) begin
            int_ex_q   <= int_issue;
            mem_addr_q <= mem_issue;
            mem_ma_q   <= mem_addr_q;
            for (int c = 0; c < CONSUMERS; c++) begin
                bypass_ctrl[c].r_a <= match_a[c];
                bypass_ctrl[c].r_b <= match_b[c];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bypass_select_generator.sv
// ============================================================================
// Module  : tb_bypass_select_generator
// Brief   : Directed self-checking bench for bypass_select_generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bypass_select_generator;
    import bypass_select_generator_pkg::*;

    localparam int INT_LANES = 2;
    localparam int MEM_LANES = 2;
    localparam int CONSUMERS = 4;
    localparam int PREG_W    = 7;

    logic clk = 1'b0;
    logic rst_n;
    logic stall;
    logic flush;
    logic [INT_LANES-1:0]             int_issue_valid;
    logic [INT_LANES-1:0]             int_writes_reg;
    logic [INT_LANES-1:0][PREG_W-1:0] int_dst;
    logic [MEM_LANES-1:0]             mem_issue_valid;
    logic [MEM_LANES-1:0]             mem_writes_reg;
    logic [MEM_LANES-1:0][PREG_W-1:0] mem_dst;
    logic [CONSUMERS-1:0]             src_valid_a;
    logic [CONSUMERS-1:0]             src_valid_b;
    logic [CONSUMERS-1:0][PREG_W-1:0] src_a;
    logic [CONSUMERS-1:0][PREG_W-1:0] src_b;
    bypass_ctrl_t [CONSUMERS-1:0]     bypass_ctrl;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] NONE = 7'd0;

    always #5 clk = ~clk;

    bypass_select_generator #(
        .INT_LANES(INT_LANES), .MEM_LANES(MEM_LANES),
        .CONSUMERS(CONSUMERS), .PREG_W(PREG_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .int_issue_valid (int_issue_valid),
        .int_writes_reg  (int_writes_reg),
        .int_dst         (int_dst),
        .mem_issue_valid (mem_issue_valid),
        .mem_writes_reg  (mem_writes_reg),
        .mem_dst         (mem_dst),
        .src_valid_a     (src_valid_a),
        .src_valid_b     (src_valid_b),
        .src_a           (src_a),
        .src_b           (src_b),
        .bypass_ctrl     (bypass_ctrl)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {valid, stg[1:0], int_lane[1:0], mem_lane[1:0]}
    function automatic logic [6:0] sel(input logic [1:0] stg, input logic [1:0] il, input logic [1:0] ml);
        return {1'b1, stg, il, ml};
    endfunction

    task automatic clear_inputs();
        stall = 0; flush = 0;
        int_issue_valid = '0; int_writes_reg = '0; int_dst = '0;
        mem_issue_valid = '0; mem_writes_reg = '0; mem_dst = '0;
        src_valid_a = '0; src_valid_b = '0; src_a = '0; src_b = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic int_issue(input int lane, input logic [PREG_W-1:0] p);
        int_issue_valid[lane] = 1'b1; int_writes_reg[lane] = 1'b1; int_dst[lane] = p;
    endtask

    task automatic mem_issue(input int lane, input logic [PREG_W-1:0] p);
        mem_issue_valid[lane] = 1'b1; mem_writes_reg[lane] = 1'b1; mem_dst[lane] = p;
    endtask

    task automatic set_a(input int c, input logic [PREG_W-1:0] p);
        src_valid_a[c] = 1'b1; src_a[c] = p;
    endtask

    task automatic set_b(input int c, input logic [PREG_W-1:0] p);
        src_valid_b[c] = 1'b1; src_b[c] = p;
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        int_issue(0, 7'd1); set_a(0, 7'd1);
        step(); step();
        check("reset_all_zero", 64'(bypass_ctrl), 64'd0);
        clear_inputs();
        rst_n = 1;

        // Integer pipe: EX, then WB, then dropped
        int_issue(0, 7'd5); set_a(0, 7'd5);
        step();
        check("int_ex_lane0", 64'(bypass_ctrl[0].r_a), 64'(sel(STG_INT_EX, 2'd0, 2'd0)));
        check("int_ex_rb_idle", 64'(bypass_ctrl[0].r_b), 64'(NONE));
        clear_inputs(); set_a(0, 7'd5);
        step();
        check("int_wb_lane0", 64'(bypass_ctrl[0].r_a), 64'(sel(STG_INT_WB, 2'd0, 2'd0)));
        step();
        check("int_dropped", 64'(bypass_ctrl[0].r_a), 64'(NONE));

        // Lane 1 seen by other consumers on both operands
        clear_inputs(); int_issue(1, 7'd6); set_a(2, 7'd6); set_b(3, 7'd6);
        step();
        check("int_ex_lane1_c2a", 64'(bypass_ctrl[2].r_a), 64'(sel(STG_INT_EX, 2'd1, 2'd0)));
        check("int_ex_lane1_c3b", 64'(bypass_ctrl[3].r_b), 64'(sel(STG_INT_EX, 2'd1, 2'd0)));

        // Memory pipe: hidden address stage, MA, WB, dropped
        clear_inputs(); mem_issue(1, 7'd9); set_b(0, 7'd9);
        step();
        check("mem_hidden_stage", 64'(bypass_ctrl[0].r_b), 64'(NONE));
        clear_inputs(); set_b(0, 7'd9);
        step();
        check("mem_ma_lane1", 64'(bypass_ctrl[0].r_b), 64'(sel(STG_MEM_MA, 2'd0, 2'd1)));
        step();
        check("mem_wb_lane1", 64'(bypass_ctrl[0].r_b), 64'(sel(STG_MEM_WB, 2'd0, 2'd1)));
        step();
        check("mem_dropped", 64'(bypass_ctrl[0].r_b), 64'(NONE));

        // MEM_MA beats INT_WB
        clear_inputs(); int_issue(1, 7'd10); mem_issue(0, 7'd10);
        step();
        clear_inputs(); set_a(1, 7'd10);
        step();
        check("prio_ma_over_wb", 64'(bypass_ctrl[1].r_a), 64'(sel(STG_MEM_MA, 2'd0, 2'd0)));

        // INT_WB beats MEM_WB
        clear_inputs(); mem_issue(0, 7'd11);
        step();
        clear_inputs(); int_issue(0, 7'd11);
        step();
        clear_inputs(); set_a(1, 7'd11);
        step();
        check("prio_wb_over_memwb", 64'(bypass_ctrl[1].r_a), 64'(sel(STG_INT_WB, 2'd0, 2'd0)));

        // Illegal rename: youngest INT_EX lane 0 wins over INT_WB lane 1
        clear_inputs(); int_issue(1, 7'd3);
        step();
        clear_inputs(); int_issue(0, 7'd3); set_a(0, 7'd3);
        step();
        check("rename_youngest", 64'(bypass_ctrl[0].r_a), 64'(sel(STG_INT_EX, 2'd0, 2'd0)));

        // Flush kills producers and zeroes outputs
        clear_inputs(); int_issue(0, 7'd7);
        step();
        clear_inputs(); flush = 1; int_issue(1, 7'd7); set_a(0, 7'd7);
        step();
        check("flush_out_zero", 64'(bypass_ctrl), 64'd0);
        clear_inputs(); set_a(0, 7'd7);
        step();
        check("flush_entries_gone", 64'(bypass_ctrl[0].r_a), 64'(NONE));

        // Flush wins over stall
        clear_inputs(); int_issue(0, 7'd8); set_a(0, 7'd8);
        step();
        check("pre_flush_stall", 64'(bypass_ctrl[0].r_a), 64'(sel(STG_INT_EX, 2'd0, 2'd0)));
        clear_inputs(); stall = 1; flush = 1; set_a(0, 7'd8);
        step();
        check("flush_over_stall", 64'(bypass_ctrl[0].r_a), 64'(NONE));

        // Stall holds entries and outputs; issue during stall is ignored
        clear_inputs(); int_issue(0, 7'd4); set_a(0, 7'd4);
        step();
        check("stall_pre", 64'(bypass_ctrl[0].r_a), 64'(sel(STG_INT_EX, 2'd0, 2'd0)));
        for (int i = 0; i < 3; i++) begin
            clear_inputs(); stall = 1; set_a(0, 7'd4); int_issue(1, 7'd12);
            step();
            check("stall_hold", 64'(bypass_ctrl[0].r_a), 64'(sel(STG_INT_EX, 2'd0, 2'd0)));
        end
        clear_inputs(); set_a(0, 7'd4); set_b(1, 7'd12);
        step();
        check("stall_release_wb", 64'(bypass_ctrl[0].r_a), 64'(sel(STG_INT_WB, 2'd0, 2'd0)));
        check("stall_issue_ignored", 64'(bypass_ctrl[1].r_b), 64'(NONE));

        // Producer that writes no register is never tracked
        clear_inputs(); int_issue_valid[0] = 1'b1; int_dst[0] = 7'd2; set_a(0, 7'd2);
        step();
        check("no_write_ex", 64'(bypass_ctrl[0].r_a), 64'(NONE));
        clear_inputs(); set_a(0, 7'd2);
        step();
        check("no_write_wb", 64'(bypass_ctrl[0].r_a), 64'(NONE));

        // Asynchronous reset mid-stream
        clear_inputs(); int_issue(0, 7'd13); set_a(0, 7'd13);
        step();
        check("pre_reset", 64'(bypass_ctrl[0].r_a), 64'(sel(STG_INT_EX, 2'd0, 2'd0)));
        clear_inputs(); set_a(0, 7'd13);
        rst_n = 0;
        #1;
        check("reset_async", 64'(bypass_ctrl), 64'd0);
        step();
        check("reset_held", 64'(bypass_ctrl), 64'd0);
        rst_n = 1;
        step();
        check("reset_entries_gone", 64'(bypass_ctrl[0].r_a), 64'(NONE));
        clear_inputs(); int_issue(0, 7'd14); set_a(0, 7'd14);
        step();
        check("post_reset_issue", 64'(bypass_ctrl[0].r_a), 64'(sel(STG_INT_EX, 2'd0, 2'd0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
